// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the 8-digit multiplexed 7-segment scanner.
//   - SEG_BLANK / SEL_NONE : all segments / all digits off (active-low).
//   - HEX_SEG              : 16-entry hex glyph table, dp off, [6:0]=g..a.
//   - state_t              : scan phase within a digit slot.
//   - msd_index()          : index of the most significant non-zero nibble
//                            (0 for a zero word); used by the optional
//                            SEG_LEADING_ZERO_BLANK_EN feature.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEL_NONE  = 8'hFF;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  function automatic logic [2:0] msd_index(input logic [31:0] value);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (value[k*4 +: 4] != 4'h0) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_display_hex_to_seg7.sv
// hex_to_seg7: combinational 4-bit to active-low 7-segment decoder.
//   nibble : in  4  hex digit to display
//   seg    : out 8  active-low segments, [7]=dp (always off), [6:0]=g..a
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: scans a 32-bit word onto an 8-digit common-anode
// multiplexed 7-segment display, one hex nibble per digit.
//   clk     : in  1   system clock, rising edge
//   rst     : in  1   asynchronous, active-low reset
//   i_en    : in  1   scan enable; low = display dark, scan position frozen
//   i_value : in  32  word to display; nibble k drives digit k
//   o_seg   : out 8   segments, active-low; [7]=dp, [6:0]=g..a
//   o_sel   : out 8   digit selects, active-low; bit k = digit k
//   o_frame : out 1   one-cycle pulse when the frame snapshot is taken
// Parameters: SCAN_DIV cycles per digit slot (>= 2); the first BLANK_CYCLES
// cycles of each slot keep every digit off to suppress ghosting
// (1 <= BLANK_CYCLES < SCAN_DIV).
// Optional build macro SEG_LEADING_ZERO_BLANK_EN: leading zero digits are
// left unlit (still selected, so scan timing does not change).
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [31:0] i_value,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        o_frame
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    digit_reg;
  logic [31:0]   snap_reg;

  logic [3:0]    nibble;
  logic [7:0]    seg_code;
  logic [7:0]    sel_code;
  logic [7:0]    show_seg;
  logic          digit_visible;
  logic          take_snap;
  logic          cnt_last;

  // The snapshot is only read during SHOW, and slot position 0 is always in
  // BLANK, so using the registered snapshot here never shows a stale frame.
  assign nibble    = snap_reg[{digit_reg, 2'b00} +: 4];
  assign sel_code  = ~(8'h01 << digit_reg);
  assign take_snap = (cnt_reg == '0) && (digit_reg == 3'd0);
  assign cnt_last  = (cnt_reg == CW'(SCAN_DIV - 1));

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_code)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [2:0] msd_reg;
  assign digit_visible = (digit_reg <= msd_reg);
`else
  assign digit_visible = 1'b1;
`endif

  assign show_seg = digit_visible ? seg_code : SEG_BLANK;

  // state_reg records the phase currently presented on the outputs; each
  // enabled edge presents the phase belonging to the current cnt_reg value
  // and then advances the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_BLANK;
      cnt_reg   <= '0;
      digit_reg <= 3'd0;
      snap_reg  <= 32'h0;
      o_seg     <= SEG_BLANK;
      o_sel     <= SEL_NONE;
      o_frame   <= 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      msd_reg   <= 3'd0;
`endif
    end else if (!i_en) begin
      // Dark while disabled; position and snapshot hold for resumption.
      o_seg   <= SEG_BLANK;
      o_sel   <= SEL_NONE;
      o_frame <= 1'b0;
    end else begin
      o_frame <= take_snap;
      if (take_snap) begin
        snap_reg <= i_value;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        msd_reg  <= msd_index(i_value);
`endif
      end

      case (state_reg)
        ST_BLANK: begin
          if (cnt_reg == CW'(BLANK_CYCLES)) begin
            state_reg <= ST_SHOW;
            o_sel     <= sel_code;
            o_seg     <= show_seg;
          end else begin
            o_sel <= SEL_NONE;
            o_seg <= SEG_BLANK;
          end
        end
        ST_SHOW: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_BLANK;
            o_sel     <= SEL_NONE;
            o_seg     <= SEG_BLANK;
          end else begin
            o_sel <= sel_code;
            o_seg <= show_seg;
          end
        end
        default: begin
          state_reg <= ST_BLANK;
          o_sel     <= SEL_NONE;
          o_seg     <= SEG_BLANK;
        end
      endcase

      if (cnt_last) begin
        cnt_reg   <= '0;
        digit_reg <= digit_reg + 3'd1;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: self-checking bench for seg_scan_display with
// SCAN_DIV=8, BLANK_CYCLES=2. A reference model predicts every output cycle
// into a scoreboard queue; each scenario task adds targeted checks.
// Honours SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan_display;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 8 * SCAN_DIV;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic [31:0] i_value = 32'h0;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;
  logic        o_frame;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] sel;
    logic [7:0] seg;
    logic       frame;
    int         cnt;
    int         dig;
  } exp_t;

  exp_t sb[$];

  int          m_cnt  = 0;
  int          m_dig  = 0;
  logic [31:0] m_snap = 32'h0;
  int          m_msd  = 0;

  seg_scan_display #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_en    (i_en),
    .i_value (i_value),
    .o_seg   (o_seg),
    .o_sel   (o_sel),
    .o_frame (o_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic int ref_msd(input logic [31:0] v);
    int r;
    r = 0;
    for (int k = 0; k < 8; k++) if (v[k*4 +: 4] != 4'h0) r = k;
    return r;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_dig  = 0;
    m_snap = 32'h0;
    m_msd  = 0;
  endtask

  // Predict this edge's outputs, queue them, clock, then pop and compare.
  task automatic run_cycle();
    exp_t e;
    exp_t got;
    logic [3:0] nib;
    e.cnt = m_cnt;
    e.dig = m_dig;
    if (!i_en) begin
      e.sel = 8'hFF; e.seg = 8'hFF; e.frame = 1'b0;
    end else begin
      e.frame = (m_cnt == 0 && m_dig == 0);
      if (e.frame) begin
        m_snap = i_value;
        m_msd  = ref_msd(i_value);
      end
      if (m_cnt < BLANK_CYCLES) begin
        e.sel = 8'hFF; e.seg = 8'hFF;
      end else begin
        e.sel = ~(8'(1) << m_dig);
        nib   = m_snap[m_dig*4 +: 4];
        e.seg = (LZ && m_dig > m_msd) ? 8'hFF : ref_seg(nib);
      end
      m_cnt++;
      if (m_cnt == SCAN_DIV) begin
        m_cnt = 0;
        m_dig = (m_dig + 1) % 8;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    n_checks++;
    if (o_sel !== got.sel || o_seg !== got.seg || o_frame !== got.frame) begin
      n_errors++;
      $display("FAIL scan d%0d c%0d: got sel=%h seg=%h frame=%b, expected sel=%h seg=%h frame=%b",
               got.dig, got.cnt, o_sel, o_seg, o_frame, got.sel, got.seg, got.frame);
    end
    if (got.cnt < BLANK_CYCLES) begin
      n_checks++;
      if (o_sel !== 8'hFF) begin
        n_errors++;
        $display("FAIL blank_interval d%0d c%0d: got sel=%h, expected ff", got.dig, got.cnt, o_sel);
      end
    end
    if (o_frame === 1'b1) $display("frame: snapshot value=%h at %0t", i_value, $time);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_checks++;
    if (o_sel !== 8'hFF || o_seg !== 8'hFF || o_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got sel=%h seg=%h frame=%b, expected ff ff 0", o_sel, o_seg, o_frame);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (o_sel !== 8'hFF || o_seg !== 8'hFF || o_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold: got sel=%h seg=%h frame=%b, expected ff ff 0", o_sel, o_seg, o_frame);
    end
    model_reset();
    i_value = 32'h76543210;
    i_en    = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_scan();
    int frames = 0;
    int first  = -1;
    int second = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      run_cycle();
      if (o_frame === 1'b1) begin
        if (frames == 0) first = i;
        else if (frames == 1) second = i;
        frames++;
      end
      if (i == 2) begin
        n_checks++;
        if (o_sel !== 8'hFE || o_seg !== 8'hC0) begin
          n_errors++;
          $display("FAIL scan_digit0: got sel=%h seg=%h, expected fe c0", o_sel, o_seg);
        end
      end
      if (i == 10) begin
        n_checks++;
        if (o_sel !== 8'hFD || o_seg !== 8'hF9) begin
          n_errors++;
          $display("FAIL scan_digit1: got sel=%h seg=%h, expected fd f9", o_sel, o_seg);
        end
      end
      if (i == 58) begin
        n_checks++;
        if (o_sel !== 8'h7F || o_seg !== 8'hF8) begin
          n_errors++;
          $display("FAIL scan_digit7: got sel=%h seg=%h, expected 7f f8", o_sel, o_seg);
        end
      end
    end
    n_checks++;
    if (frames != 2 || first != 0 || second != FRAME) begin
      n_errors++;
      $display("FAIL frame_period: got %0d pulses at %0d,%0d, expected 2 at 0,%0d",
               frames, first, second, FRAME);
    end
  endtask

  task automatic test_snapshot_hold();
    for (int i = 0; i < FRAME; i++) begin
      if (i == 27) i_value = 32'hFFFFFFFF;
      run_cycle();
      if (i == 43) begin
        n_checks++;
        if (o_sel !== 8'hDF || o_seg !== 8'h92) begin
          n_errors++;
          $display("FAIL snapshot_hold: got sel=%h seg=%h, expected df 92", o_sel, o_seg);
        end
      end
    end
    for (int i = 0; i < FRAME; i++) begin
      run_cycle();
      if (i == 2 || i == 43) begin
        n_checks++;
        if (o_seg !== 8'h8E) begin
          n_errors++;
          $display("FAIL snapshot_next_frame i=%0d: got seg=%h, expected 8e", i, o_seg);
        end
      end
    end
  endtask

  task automatic test_decode_high();
    i_value = 32'hFEDCBA98;
    for (int i = 0; i < FRAME; i++) begin
      run_cycle();
      if (i == 2 || i == 34 || i == 58) begin
        n_checks++;
        if (o_seg !== ref_seg(4'(8 + i / 8))) begin
          n_errors++;
          $display("FAIL decode_high i=%0d: got seg=%h, expected %h", i, o_seg, ref_seg(4'(8 + i / 8)));
        end
      end
    end
  endtask

  task automatic test_enable_gate();
    int extra = 0;
    for (int i = 0; i < 20; i++) run_cycle();
    i_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      if (o_frame === 1'b1) extra++;
      if (k == 0) begin
        n_checks++;
        if (o_sel !== 8'hFF || o_seg !== 8'hFF) begin
          n_errors++;
          $display("FAIL enable_dark: got sel=%h seg=%h, expected ff ff", o_sel, o_seg);
        end
      end
    end
    i_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      if (o_frame === 1'b1) extra++;
      n_checks++;
      if (o_sel !== 8'hFB || o_seg !== 8'h88) begin
        n_errors++;
        $display("FAIL enable_resume k=%0d: got sel=%h seg=%h, expected fb 88", k, o_sel, o_seg);
      end
    end
    run_cycle();
    n_checks++;
    if (o_sel !== 8'hFF) begin
      n_errors++;
      $display("FAIL enable_next_slot: got sel=%h, expected ff", o_sel);
    end
    n_checks++;
    if (extra != 0) begin
      n_errors++;
      $display("FAIL enable_no_frame: got %0d pulses, expected 0", extra);
    end
    for (int i = 0; i < FRAME - 25; i++) run_cycle();
  endtask

  task automatic test_reset_mid();
    int frames = 0;
    for (int i = 0; i < 44; i++) run_cycle();
    n_checks++;
    if (o_sel !== 8'hDF || o_seg !== 8'hA1) begin
      n_errors++;
      $display("FAIL pre_reset_digit5: got sel=%h seg=%h, expected df a1", o_sel, o_seg);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (o_sel !== 8'hFF || o_seg !== 8'hFF || o_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: got sel=%h seg=%h frame=%b, expected ff ff 0", o_sel, o_seg, o_frame);
    end
    model_reset();
    i_value = 32'h0BADF00D;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      run_cycle();
      if (o_frame === 1'b1) begin
        frames++;
        n_checks++;
        if (i != 0) begin
          n_errors++;
          $display("FAIL reset_restart_frame: got pulse at %0d, expected 0", i);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (o_sel !== 8'hFE || o_seg !== 8'hA1) begin
          n_errors++;
          $display("FAIL reset_restart_digit0: got sel=%h seg=%h, expected fe a1", o_sel, o_seg);
        end
      end
    end
    n_checks++;
    if (frames != 1) begin
      n_errors++;
      $display("FAIL reset_frame_count: got %0d, expected 1", frames);
    end
  endtask

  task automatic test_leading_zero();
    i_value = 32'h000000A0;
    for (int i = 0; i < FRAME; i++) begin
      run_cycle();
      if (i == 10) begin
        n_checks++;
        if (o_sel !== 8'hFD || o_seg !== 8'h88) begin
          n_errors++;
          $display("FAIL lz_digit1: got sel=%h seg=%h, expected fd 88", o_sel, o_seg);
        end
      end
      if (i == 58) begin
        n_checks++;
        if (o_sel !== 8'h7F || o_seg !== (LZ ? 8'hFF : 8'hC0)) begin
          n_errors++;
          $display("FAIL lz_digit7: got sel=%h seg=%h, expected 7f %h", o_sel, o_seg, LZ ? 8'hFF : 8'hC0);
        end
      end
    end
    i_value = 32'h0;
    for (int i = 0; i < FRAME; i++) begin
      run_cycle();
      if (i == 2) begin
        n_checks++;
        if (o_sel !== 8'hFE || o_seg !== 8'hC0) begin
          n_errors++;
          $display("FAIL lz_zero_digit0: got sel=%h seg=%h, expected fe c0", o_sel, o_seg);
        end
      end
      if (i == 10) begin
        n_checks++;
        if (o_seg !== (LZ ? 8'hFF : 8'hC0)) begin
          n_errors++;
          $display("FAIL lz_zero_digit1: got seg=%h, expected %h", o_seg, LZ ? 8'hFF : 8'hC0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot_hold();
    test_decode_high();
    test_enable_gate();
    test_reset_mid();
    test_leading_zero();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
